// File: rtl/hd63701_irq2_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hd63701_irq2_ctrl
// Purpose  : IRQ2 interrupt controller for the HD63701 core. Latches one-cycle
//            event pulses from on-chip peripherals, masks them, selects the
//            lowest-index (highest-priority) active source and presents a
//            stable request/vector pair to the sequencer. The serviced pending
//            bit is cleared when the core acknowledges the vector fetch.
// Ports    : CLK     core clock
//            RST_N   asynchronous active-low reset
//            SRC_EV  per-source event pulses (bit i = source i)
//            CS/WR/A/DI  register port strobe, direction, address, write data
//            DO      read data, combinational from A
//            VACK    vector-fetch acknowledge pulse from the core
//            IRQ2    registered interrupt request
//            IRQ2V   registered vector code (winning source index)
//            Register map: A=0 PEND (R/W1C), A=1 MASK (R/W),
//                          A=2 STAT {IRQ2,3'b0,IRQ2V} (R), A=3 reads 0
// Revision : 1.0 - initial release
// ============================================================================
module hd63701_irq2_ctrl #(
  parameter int         NSRC = 5,      // number of sources, 1..8
  parameter logic [7:0] MRST = 8'h00   // MASK reset value
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [NSRC-1:0] SRC_EV,
  input  logic            CS,
  input  logic            WR,
  input  logic [1:0]      A,
  input  logic [7:0]      DI,
  output logic [7:0]      DO,
  input  logic            VACK,
  output logic            IRQ2,
  output logic [3:0]      IRQ2V
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ASSERT = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] act;
  logic [NSRC-1:0] w1c;
  logic [NSRC-1:0] ackclr;
  logic [3:0]      win;
  logic            act_cur;
  logic            irq2_nxt;
  logic [3:0]      irq2v_nxt;
  logic            wr_pend;
  logic            wr_mask;
  logic            unused_ok;

  // Write data bits above NSRC have no storage behind them.
  assign unused_ok = ^DI;

  assign wr_pend = CS & WR & (A == 2'd0);
  assign wr_mask = CS & WR & (A == 2'd1);
  assign w1c     = wr_pend ? DI[NSRC-1:0] : '0;
  assign act     = pend & mask;

  // Lowest set index wins; scanning downward lets the lowest index land last.
  always_comb begin
    win = 4'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (act[i]) win = 4'(i);
    end
  end

  // Is the source currently being presented still active?
  always_comb begin
    act_cur = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (IRQ2V == 4'(i)) act_cur = act[i];
    end
  end

  // Acknowledge clears only the source whose vector was presented.
  always_comb begin
    ackclr = '0;
    if (state == ST_ASSERT && VACK) begin
      for (int i = 0; i < NSRC; i++) begin
        if (IRQ2V == 4'(i)) ackclr[i] = 1'b1;
      end
    end
  end

  // A new event always outranks a same-cycle clear (W1C or acknowledge).
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend <= '0;
      mask <= MRST[NSRC-1:0];
    end else begin
      pend <= SRC_EV | (pend & ~w1c & ~ackclr);
      if (wr_mask) mask <= DI[NSRC-1:0];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= ST_IDLE;
      IRQ2  <= 1'b0;
      IRQ2V <= 4'd0;
    end else begin
      state <= state_nxt;
      IRQ2  <= irq2_nxt;
      IRQ2V <= irq2v_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    irq2_nxt  = IRQ2;
    irq2v_nxt = IRQ2V;
    unique case (state)
      ST_IDLE: begin
        irq2_nxt = 1'b0;
        if (act != '0) begin
          state_nxt = ST_ASSERT;
          irq2_nxt  = 1'b1;
          irq2v_nxt = win;
        end
      end
      ST_ASSERT: begin
        // Vector is frozen while asserted; acknowledge beats withdrawal.
        if (VACK) begin
          state_nxt = ST_GAP;
          irq2_nxt  = 1'b0;
        end else if (!act_cur) begin
          state_nxt = ST_IDLE;
          irq2_nxt  = 1'b0;
        end
      end
      ST_GAP: begin
        // Guarantees the core sees a deassertion edge between requests.
        state_nxt = ST_IDLE;
        irq2_nxt  = 1'b0;
      end
      default: begin
        state_nxt = ST_IDLE;
        irq2_nxt  = 1'b0;
      end
    endcase
  end

  always_comb begin
    DO = 8'h00;
    unique case (A)
      2'd0:    DO[NSRC-1:0] = pend;
      2'd1:    DO[NSRC-1:0] = mask;
      2'd2:    DO = {IRQ2, 3'b000, IRQ2V};
      default: DO = 8'h00;
    endcase
  end

endmodule
`default_nettype wire
